// File: rtl/bsg_fifo_1r1w_rolly_gen_pkg.sv
// Shared sizing helpers for the speculative-read (rolly) FIFO.
// No ports; imported by the interface, pointer and top modules.
package bsg_fifo_1r1w_rolly_gen_pkg;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned bsg_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_rolly_gen_if.sv
// Handshake/bus bundle for bsg_fifo_1r1w_rolly_gen.
// slave  : FIFO side (consumes enqueue, read, commit, roll and clear requests;
//          produces ready, read data, valid and occupancy counts).
// master : producer/consumer side, the mirror image.
interface bsg_fifo_1r1w_rolly_gen_if
    import bsg_fifo_1r1w_rolly_gen_pkg::*;
#(
    parameter int unsigned width_p      = 16,
    parameter int unsigned els_p        = 8,
    parameter int unsigned commit_max_p = 1
);
    localparam int unsigned cnt_width_lp = bsg_width(els_p);
    localparam int unsigned cmt_width_lp = bsg_width(commit_max_p);

    // enqueue side
    logic [width_p-1:0]      data_i;
    logic                    v_i;
    logic                    ready_o;

    // speculative read side
    logic [width_p-1:0]      data_o;
    logic                    v_o;
    logic                    yumi_i;
    logic [cmt_width_lp-1:0] commit_cnt_i;
    logic                    roll_v_i;
    logic                    clr_v_i;

    // occupancy
    logic [cnt_width_lp-1:0] space_o;
    logic [cnt_width_lp-1:0] unread_o;
    logic [cnt_width_lp-1:0] inflight_o;

    modport slave (
        input  data_i, v_i, yumi_i, commit_cnt_i, roll_v_i, clr_v_i,
        output ready_o, data_o, v_o, space_o, unread_o, inflight_o
    );

    modport master (
        output data_i, v_i, yumi_i, commit_cnt_i, roll_v_i, clr_v_i,
        input  ready_o, data_o, v_o, space_o, unread_o, inflight_o
    );

endinterface

// File: rtl/bsg_fifo_1r1w_rolly_gen_ptr.sv
// Circular pointer over slots_p positions (slots_p a power of two) that
// advances by add_i (0..max_add_p) each cycle.
// Ports: clk_i, reset_i (sync, active-high, clears to 0), add_i increment,
//        o registered pointer, n_o next-cycle pointer.
module bsg_fifo_1r1w_rolly_gen_ptr
    import bsg_fifo_1r1w_rolly_gen_pkg::*;
#(
    parameter int unsigned slots_p   = 16,
    parameter int unsigned max_add_p = 1,
    localparam int unsigned ptr_w_lp = $clog2(slots_p),
    localparam int unsigned add_w_lp = bsg_width(max_add_p)
)(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [add_w_lp-1:0] add_i,
    output logic [ptr_w_lp-1:0] o,
    output logic [ptr_w_lp-1:0] n_o
);
    logic [ptr_w_lp-1:0] ptr_q;
    logic [ptr_w_lp-1:0] ptr_d;

    // slots_p is a power of two, so natural truncation is the modulo.
    always_comb begin
        ptr_d = ptr_q + ptr_w_lp'(add_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign o   = ptr_q;
    assign n_o = ptr_d;

endmodule

// File: rtl/bsg_fifo_1r1w_rolly_gen.sv
// Speculative-read FIFO. Writes enqueue at wptr; reads advance rptr
// speculatively; entries only free when committed (cptr advances).
// roll_v_i rewinds rptr to the commit point (replay); clr_v_i drops all
// unread entries by pulling wptr back to rptr.
// Ports: clk_i, reset_i (sync, active-high), fifo_if (slave modport) carrying
//        enqueue (data_i/v_i/ready_o), read (data_o/v_o/yumi_i), commit_cnt_i,
//        roll_v_i, clr_v_i and occupancy counts space_o/unread_o/inflight_o.
module bsg_fifo_1r1w_rolly_gen
    import bsg_fifo_1r1w_rolly_gen_pkg::*;
#(
    parameter int unsigned width_p      = 16,
    parameter int unsigned els_p        = 8,
    parameter int unsigned commit_max_p = 1
)(
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_fifo_1r1w_rolly_gen_if.slave    fifo_if
);
    localparam int unsigned addr_w_lp = $clog2(els_p);
    localparam int unsigned ptr_w_lp  = addr_w_lp + 1;
    localparam int unsigned slots_lp  = 2 * els_p;
    localparam int unsigned cmt_w_lp  = bsg_width(commit_max_p);
    localparam int unsigned jump_w_lp = bsg_width(slots_lp - 1);

    logic [ptr_w_lp-1:0] cptr_q, rptr_q, wptr_q;
    logic [ptr_w_lp-1:0] cptr_n, rptr_n, wptr_n;

    logic                 empty, full;
    logic                 v_lo, ready_lo;
    logic                 enq, deq;
    logic [ptr_w_lp-1:0]  cptr_target;
    logic [jump_w_lp-1:0] rptr_add, wptr_add;

    // Status from registered pointers only: a commit this cycle frees space next cycle.
    assign empty    = (rptr_q == wptr_q);
    assign full     = (cptr_q[addr_w_lp-1:0] == wptr_q[addr_w_lp-1:0])
                   && (cptr_q[addr_w_lp]     != wptr_q[addr_w_lp]);
    assign v_lo     = ~fifo_if.roll_v_i & ~empty;
    assign ready_lo = ~fifo_if.clr_v_i  & ~full;
    assign enq      = fifo_if.v_i    & ready_lo;
    assign deq      = fifo_if.yumi_i & v_lo;

    // Roll and clear are expressed as forward jumps (mod 2*els_p) so every
    // pointer stays a plain add-only circular counter.
    always_comb begin
        cptr_target = cptr_q + ptr_w_lp'(fifo_if.commit_cnt_i);
        rptr_add    = jump_w_lp'(deq);
        wptr_add    = jump_w_lp'(enq);
        if (fifo_if.roll_v_i) begin
            rptr_add = jump_w_lp'(cptr_target - rptr_q);
        end
        if (fifo_if.clr_v_i) begin
            // deq is 0 under roll, so roll+clear lands wptr on the old rptr.
            wptr_add = jump_w_lp'((rptr_q + ptr_w_lp'(deq)) - wptr_q);
        end
    end

    bsg_fifo_1r1w_rolly_gen_ptr #(
        .slots_p   (slots_lp),
        .max_add_p (commit_max_p)
    ) u_cptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .add_i   (fifo_if.commit_cnt_i),
        .o       (cptr_q),
        .n_o     (cptr_n)
    );

    bsg_fifo_1r1w_rolly_gen_ptr #(
        .slots_p   (slots_lp),
        .max_add_p (slots_lp - 1)
    ) u_rptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .add_i   (rptr_add),
        .o       (rptr_q),
        .n_o     (rptr_n)
    );

    bsg_fifo_1r1w_rolly_gen_ptr #(
        .slots_p   (slots_lp),
        .max_add_p (slots_lp - 1)
    ) u_wptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .add_i   (wptr_add),
        .o       (wptr_q),
        .n_o     (wptr_n)
    );

    // Storage: contents need no reset; visibility is governed by the pointers.
    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q[addr_w_lp-1:0]] <= fifo_if.data_i;
    end

    assign fifo_if.data_o     = mem_q[rptr_q[addr_w_lp-1:0]];
    assign fifo_if.v_o        = v_lo;
    assign fifo_if.ready_o    = ready_lo;
    assign fifo_if.space_o    = ptr_w_lp'(els_p) - (wptr_q - cptr_q);
    assign fifo_if.unread_o   = wptr_q - rptr_q;
    assign fifo_if.inflight_o = rptr_q - cptr_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (is_pow2(els_p) && els_p >= 2)
                else $error("els_p must be a power of two >= 2");
            assert (commit_max_p >= 1 && commit_max_p <= els_p)
                else $error("commit_max_p out of range");
            assert (!(fifo_if.yumi_i && !v_lo))
                else $error("yumi_i asserted without v_o");
            assert (ptr_w_lp'(fifo_if.commit_cnt_i) <= (rptr_q - cptr_q))
                else $error("commit_cnt_i exceeds inflight entries");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_gen.sv
module tb_bsg_fifo_1r1w_rolly_gen;
    localparam int unsigned W = 16;
    localparam int unsigned E = 8;
    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bsg_fifo_1r1w_rolly_gen_if #(.width_p(W), .els_p(E), .commit_max_p(C)) fif ();

    bsg_fifo_1r1w_rolly_gen #(.width_p(W), .els_p(E), .commit_max_p(C)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .fifo_if (fif)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted read must match the next expected payload.
    always @(negedge clk) begin
        if (!reset && fif.v_o && fif.yumi_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got 0x%0h expected none", fif.data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_data", int'(fif.data_o), int'(mon_exp));
            end
        end
    end

    task automatic idle();
        fif.v_i          = 1'b0;
        fif.data_i       = '0;
        fif.yumi_i       = 1'b0;
        fif.commit_cnt_i = '0;
        fif.roll_v_i     = 1'b0;
        fif.clr_v_i      = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic enq(input logic [W-1:0] d);
        fif.v_i    = 1'b1;
        fif.data_i = d;
    endtask

    task automatic rd(input logic [W-1:0] e);
        fif.yumi_i = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_v_o", fif.v_o, 0);
        chk("rst_ready", fif.ready_o, 1);
        chk("rst_space", fif.space_o, 8);
        chk("rst_unread", fif.unread_o, 0);
        chk("rst_inflight", fif.inflight_o, 0);
        adv();

        // 1: fill to full, 9th write refused
        for (int i = 0; i < 8; i++) begin
            enq(16'hA0 + 16'(i));
            @(negedge clk);
            chk("t1_ready", fif.ready_o, 1);
            adv();
        end
        enq(16'hA8);
        @(negedge clk);
        chk("t1_full_ready", fif.ready_o, 0);
        chk("t1_full_space", fif.space_o, 0);
        chk("t1_full_unread", fif.unread_o, 8);
        adv();
        @(negedge clk);
        chk("t1_no_9th", fif.unread_o, 8);
        adv();

        // 2: read 3, commit 2 (space only returns the cycle after)
        for (int i = 0; i < 3; i++) begin
            rd(16'hA0 + 16'(i));
            @(negedge clk);
            chk("t2_v_o", fif.v_o, 1);
            adv();
        end
        fif.commit_cnt_i = 3'd2;
        @(negedge clk);
        chk("t2_ready_commit_cycle", fif.ready_o, 0);
        adv();
        @(negedge clk);
        chk("t2_inflight", fif.inflight_o, 1);
        chk("t2_unread", fif.unread_o, 5);
        chk("t2_space", fif.space_o, 2);
        chk("t2_data", fif.data_o, 16'hA3);
        chk("t2_ready", fif.ready_o, 1);
        adv();

        // 3: read A0..A3, roll with commit 1 -> replay from A1
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            enq(16'hA0 + 16'(i));
            adv();
        end
        for (int i = 0; i < 4; i++) begin
            rd(16'hA0 + 16'(i));
            adv();
        end
        fif.roll_v_i     = 1'b1;
        fif.commit_cnt_i = 3'd1;
        @(negedge clk);
        chk("t3_v_o_roll", fif.v_o, 0);
        adv();
        @(negedge clk);
        chk("t3_data", fif.data_o, 16'hA1);
        chk("t3_v_o", fif.v_o, 1);
        chk("t3_inflight", fif.inflight_o, 0);
        chk("t3_unread", fif.unread_o, 5);
        for (int i = 1; i < 6; i++) begin
            rd(16'hA0 + 16'(i));
            adv();
        end

        // 4: clear with a same-cycle read keeps the read entry
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            enq(16'hB0 + 16'(i));
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            rd(16'hB0 + 16'(i));
            adv();
        end
        fif.clr_v_i = 1'b1;
        rd(16'hB2);
        enq(16'h00EE);
        @(negedge clk);
        chk("t4_ready_clr", fif.ready_o, 0);
        adv();
        @(negedge clk);
        chk("t4_unread", fif.unread_o, 0);
        chk("t4_inflight", fif.inflight_o, 3);
        chk("t4_space", fif.space_o, 5);
        chk("t4_ready_after", fif.ready_o, 1);
        chk("t4_v_o", fif.v_o, 0);
        fif.commit_cnt_i = 3'd3;
        adv();
        @(negedge clk);
        chk("t4_space_committed", fif.space_o, 8);
        adv();

        // 5: streaming across two pointer wraps
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            if (i < 20) enq(16'hC000 + 16'(i));
            if (i >= 1 && i <= 20) rd(16'hC000 + 16'(i - 1));
            if (i >= 5 && (i % 4) == 1) fif.commit_cnt_i = 3'd4;
            @(negedge clk);
            if (i < 20) chk("t5_ready", fif.ready_o, 1);
            if (i >= 1 && i <= 20) chk("t5_v_o", fif.v_o, 1);
            adv();
        end
        @(negedge clk);
        chk("t5_unread", fif.unread_o, 0);
        chk("t5_inflight", fif.inflight_o, 0);
        chk("t5_space", fif.space_o, 8);
        adv();

        // 6: reset mid-stream discards contents
        for (int i = 0; i < 5; i++) begin
            enq(16'hD0 + 16'(i));
            adv();
        end
        reset = 1'b1;
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_v_o", fif.v_o, 0);
        chk("t6_space", fif.space_o, 8);
        chk("t6_unread", fif.unread_o, 0);
        adv();
        @(negedge clk);
        chk("t6_v_o_hold", fif.v_o, 0);
        enq(16'h00E0);
        adv();
        rd(16'h00E0);
        adv();
        adv();

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
